// File: rtl/hm_sched_if.sv
// Requester/engine bundle for the host-memory page-read scheduler.
// The slave modport is the scheduler side; the master modport is its environment.
interface hm_sched_if;
    logic        req0_valid, req1_valid;
    logic [63:0] req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic        req0_done, req1_done;
    logic        req0_error, req1_error;
    logic        hm_start;
    logic [63:0] hm_address;
    logic        hm_idle, hm_end, hm_tx_timeout, hm_rx_timeout;
    logic        busy, grant_id;

    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr,
               hm_idle, hm_end, hm_tx_timeout, hm_rx_timeout,
        input  req0_ready, req1_ready, req0_done, req1_done, req0_error, req1_error,
               hm_start, hm_address, busy, grant_id
    );

    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr,
               hm_idle, hm_end, hm_tx_timeout, hm_rx_timeout,
        output req0_ready, req1_ready, req0_done, req1_done, req0_error, req1_error,
               hm_start, hm_address, busy, grant_id
    );
endinterface

// File: rtl/hm_sched.sv
// Two-requester round-robin scheduler driving a host-memory page-read engine.
// Define HM_SCHED_RETRY_EN to reissue timed-out reads up to RETRY_MAX times.
module hm_sched #(
    parameter int unsigned RETRY_MAX   = 3,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input logic       sys_clk,
    input logic       sys_rst,
    hm_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [15:0] WDOG = 16'(WDOG_CYCLES);

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic        gid_q, gid_d;
    logic        prio_q, prio_d;
    logic [1:0]  ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic        start_q, start_d;
    logic [15:0] wdog_q, wdog_d;
    logic        gnt, timeout;
`ifdef HM_SCHED_RETRY_EN
    localparam logic [3:0] RMAX = 4'(RETRY_MAX);
    logic [3:0]  retry_q, retry_d;
`endif

    // prio_q names the requester that wins a tie; it flips to the loser on each grant
    assign gnt     = bus.req1_valid & (~bus.req0_valid | prio_q);
    assign timeout = bus.hm_tx_timeout | bus.hm_rx_timeout | (wdog_q >= WDOG);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        gid_d   = gid_q;
        prio_d  = prio_q;
        wdog_d  = wdog_q;
        ready_d = '0;
        done_d  = '0;
        err_d   = '0;
        start_d = 1'b0;
`ifdef HM_SCHED_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            IDLE: if (bus.req0_valid | bus.req1_valid) begin
                gid_d        = gnt;
                prio_d       = ~gnt;
                ready_d[gnt] = 1'b1;
                addr_d       = (gnt ? bus.req1_addr : bus.req0_addr) & ~64'hFFF;
                state_d      = ISSUE;
            end
            ISSUE: if (bus.hm_idle) begin
                start_d = 1'b1;
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wdog_q != 16'hFFFF) wdog_d = wdog_q + 16'd1;
                // completion beats a coincident timeout
                if (bus.hm_end) begin
                    done_d[gid_q] = 1'b1;
                    state_d       = RESP;
                end else if (timeout) begin
`ifdef HM_SCHED_RETRY_EN
                    if (retry_q < RMAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ISSUE;
                    end else begin
                        err_d[gid_q] = 1'b1;
                        state_d      = RESP;
                    end
`else
                    err_d[gid_q] = 1'b1;
                    state_d      = RESP;
`endif
                end
            end
            RESP: begin
`ifdef HM_SCHED_RETRY_EN
                retry_d = '0;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            gid_q   <= 1'b0;
            prio_q  <= 1'b0;
            wdog_q  <= '0;
            ready_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
`ifdef HM_SCHED_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gid_q   <= gid_d;
            prio_q  <= prio_d;
            wdog_q  <= wdog_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
`ifdef HM_SCHED_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign bus.req0_ready = ready_q[0];
    assign bus.req1_ready = ready_q[1];
    assign bus.req0_done  = done_q[0];
    assign bus.req1_done  = done_q[1];
    assign bus.req0_error = err_q[0];
    assign bus.req1_error = err_q[1];
    assign bus.hm_start   = start_q;
    assign bus.hm_address = addr_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_id   = gid_q;
endmodule

// File: doc/hm_sched.md
HM_SCHED -- requirements
Module: hm_sched

Interface
REQ-001 SHALL have parameter RETRY_MAX, default 3: reissues allowed per request after a timeout (range 0..15).
REQ-002 SHALL have parameter WDOG_CYCLES, default 65535: maximum WAIT cycles before a watchdog timeout (16-bit).
REQ-003 SHALL have one clock and a synchronous active-high reset.
REQ-004 sys_clk  in  1  clock; every register is updated on its rising edge.
REQ-005 sys_rst  in  1  synchronous reset, active high.
REQ-006 req0_valid, req1_valid  in  1 each  requester n has a page read pending.
REQ-007 req0_addr, req1_addr  in  64 each  host address for requester n.
REQ-008 req0_ready, req1_ready  out  1 each  accept strobe for requester n.
REQ-009 req0_done, req1_done  out  1 each  one-cycle pulse: read completed.
REQ-010 req0_error, req1_error  out  1 each  one-cycle pulse: read failed.
REQ-011 hm_start  out  1  one-cycle start pulse to the host-memory engine.
REQ-012 hm_address  out  64  page-aligned address to the engine.
REQ-013 hm_idle  in  1  engine is in its idle state.
REQ-014 hm_end, hm_tx_timeout, hm_rx_timeout  in  1 each  single-cycle engine events.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 grant_id  out  1  index of the requester currently being served.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: when at least one valid is high, SHALL grant one requester, pulse its ready for 1 cycle, latch {addr[63:12],12'h000} into hm_address and go to ISSUE.
REQ-019 Arbitration SHALL be round-robin: when both valids are high, grant the requester not served last.
REQ-020 Round-robin after reset: requester 0 has priority.
REQ-021 ISSUE: SHALL wait until hm_idle=1, then pulse hm_start for 1 cycle, clear the watchdog counter and go to WAIT.
REQ-022 WAIT: on hm_end, SHALL go to RESP with result OK.
REQ-023 WAIT: on hm_tx_timeout, hm_rx_timeout, or the watchdog counter reaching WDOG_CYCLES, SHALL treat the event as a timeout.
REQ-024 On a timeout with retry_cnt < RETRY_MAX, SHALL increment retry_cnt and return to ISSUE; otherwise go to RESP with result ERR.
REQ-025 If hm_end and a timeout occur in the same cycle, hm_end SHALL win.
REQ-026 RESP: SHALL pulse done or error of grant_id for exactly 1 cycle, clear retry_cnt and return to IDLE.
REQ-027 Minimum latency SHALL be ready→hm_start 1 cycle and hm_end→done 1 cycle; a new grant is possible on the cycle after RESP.
REQ-028 hm_address SHALL stay stable from grant until RESP; requester inputs are ignored outside IDLE.
REQ-029 The watchdog counter SHALL be 16-bit, saturating, and count only in WAIT.
REQ-030 Engine events received outside WAIT SHALL be ignored.

Reset
REQ-031 On reset SHALL enter IDLE and clear retry_cnt, the watchdog counter and the round-robin pointer.
REQ-032 Reset values SHALL be 0 for hm_start, hm_address, all ready/done/error outputs, busy and grant_id.
REQ-033 Reset mid-operation SHALL abandon the request with no done/error pulse.

Configuration
REQ-034 Macro HM_SCHED_RETRY_EN SHALL control the retry logic.
REQ-035 With HM_SCHED_RETRY_EN defined, timeouts SHALL be retried per REQ-024.
REQ-036 Without HM_SCHED_RETRY_EN, the retry counter SHALL be absent, RETRY_MAX ignored, and the first timeout SHALL go directly to RESP with ERR.

Verification
REQ-037 req0_valid, addr 0x0000_0001_2345_6ABC, hm_idle=1 -> req0_ready at T+1, hm_start at T+2 with hm_address 0x0000_0001_2345_6000; hm_end 10 cycles later -> req0_done 1 cycle after it.
REQ-038 Both valids high for 3 back-to-back transactions -> grant order 0,1,0.
REQ-039 RETRY_EN defined, RETRY_MAX=2, hm_rx_timeout on every attempt -> 3 hm_start pulses, then one error pulse; RETRY_EN undefined -> 1 hm_start, then error.
REQ-040 WDOG_CYCLES=100 with no engine event -> timeout taken exactly 100 cycles after hm_start.
REQ-041 hm_end and hm_tx_timeout in the same cycle -> done, no retry; hm_idle=0 in ISSUE -> hm_start held off until hm_idle=1.
REQ-042 sys_rst asserted in WAIT -> next cycle all outputs 0, busy 0, no done/error pulse.
